uart_rx_parity_chk: RTL and testbench
=====================================

# uart_rx_parity_chk

Parametrised, bit-serial parity checker for the UART receive path. It accumulates parity over DATA_WIDTH sampled data bits as the RX sampler delivers them. It then compares the accumulated value against the received parity bit and reports a registered done/error pulse to the RX FSM. It generalises the transmit-side even/odd parity calculator with configurable width, mark/space modes, parity-disable and a frame-abort path.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame; legal 5..9.
- CNT_WIDTH, 8: width of the optional parity-error counter.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- PAR_EN  in  1  parity bit present in frame; sampled at frame_start.
- PAR_TYP  in  2  parity mode, sampled at frame_start: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- frame_start  in  1  one-cycle pulse at the end of the start bit; clears and arms the checker.
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid in this cycle.
- sampled_bit  in  1  majority-voted RX bit.
- busy  out  1  high while a frame is being checked (state != IDLE).
- par_done  out  1  one-cycle pulse: frame check complete.
- par_err  out  1  one-cycle pulse coincident with par_done; parity mismatch.
- par_err_cnt  out  CNT_WIDTH  saturating error count; present only with UART_PAR_ERR_CNT_EN.

## Operation
- State machine: IDLE, DATA, PARITY.
- In any state, frame_start:
  - latches PAR_EN and PAR_TYP into cfg registers;
  - clears acc and bit_cnt;
  - moves to DATA.
  - frame_start in DATA/PARITY aborts the current frame: no par_done, and the checker restarts.
- DATA, on each bit_valid:
  - acc <= acc ^ sampled_bit; bit_cnt++.
  - On the strobe where bit_cnt == DATA_WIDTH-1:
    - if cfg PAR_EN is set, go to PARITY;
    - otherwise pulse par_done with par_err=0 and go to IDLE.
- PARITY, on bit_valid:
  - Expected bit: even = acc; odd = ~acc; mark = 1; space = 0.
  - par_err = (sampled_bit != expected); pulse par_done; go to IDLE.
- IDLE: bit_valid is ignored and all outputs stay 0.
- Changing PAR_EN/PAR_TYP mid-frame has no effect until the next frame_start.
- bit_cnt width: $clog2(DATA_WIDTH) bits; the counter never wraps because the state exits at DATA_WIDTH-1.
- frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.

## Timing
- Reset (RST=0 at a clock edge) drives: state IDLE, acc 0, bit_cnt 0, cfg 0, busy 0, par_done 0, par_err 0, par_err_cnt 0.
- Reset during a frame drops that frame silently.
- busy rises the cycle after frame_start and falls the cycle after the final strobe.
- Latency: par_done/par_err are registered and assert exactly 1 cycle after the bit_valid of the last bit of the frame (the parity bit, or data bit DATA_WIDTH-1 when parity is disabled).
- par_done/par_err are high for exactly one cycle.
- Back-to-back: frame_start is accepted in the same cycle par_done is high.
- Minimum spacing between bit_valid strobes: 1 cycle (consecutive strobes are legal).

## Configuration
- Macro UART_PAR_ERR_CNT_EN.
- Defined:
  - par_err_cnt port and counter exist.
  - Increments by 1 in the same cycle par_err is asserted.
  - Saturates at 2^CNT_WIDTH-1.
  - Cleared only by RST.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] par_typ_e {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE};
  - typedef enum state type for IDLE/DATA/PARITY;
  - localparam UART_MIN_DW=5, UART_MAX_DW=9.
- Elaboration check: DATA_WIDTH is within UART_MIN_DW..UART_MAX_DW.
- One sub-module: uart_par_expected. It is combinational, maps (cfg PAR_TYP, acc) to the expected parity bit, and is reusable by the TX-side successor.
- FSM, counter and error counter live in the top module.

## Test plan
- DATA_WIDTH=8, even, PAR_EN=1, data 8'hA5 LSB-first, parity bit 0 -> par_done=1, par_err=0, one cycle after the 9th strobe.
- Same frame with PAR_TYP=odd, parity bit 0 -> par_err=1; with the macro defined, par_err_cnt goes 0->1.
- DATA_WIDTH=7, mark mode, data 7'h00, parity bit 0 -> par_err=1. Same frame in space mode -> par_err=0.
- PAR_EN=0, DATA_WIDTH=8, data 8'hFF -> par_done after the 8th strobe with par_err=0. A 9th strobe is ignored (state IDLE, busy=0).
- frame_start after 4 data bits, then a full even frame 8'h01 with parity bit 1 -> exactly one par_done, par_err=0. RST low mid-frame -> all outputs 0 next cycle and no par_done.
- Macro defined, CNT_WIDTH=2, five consecutive bad-parity frames -> par_err_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, checker states and legal data-width range.
package uart_pkg;

   typedef enum logic [1:0] {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE} par_typ_e;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY} par_state_e;

   localparam int UART_MIN_DW = 5;
   localparam int UART_MAX_DW = 9;

endpackage

// File: rtl/uart_par_expected.sv
// Expected parity bit for a given mode and accumulated XOR of the data bits.
// Purely combinational so the TX side can share it.
module uart_par_expected
   import uart_pkg::*;
(
   input  logic [1:0] par_typ,
   input  logic       acc,
   output logic       exp_bit
);

   always_comb begin
      exp_bit = 1'b0;
      case (par_typ_e'(par_typ))
         PAR_EVEN:  exp_bit = acc;
         PAR_ODD:   exp_bit = ~acc;
         PAR_MARK:  exp_bit = 1'b1;
         PAR_SPACE: exp_bit = 1'b0;
         default:   exp_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_rx_parity_chk.sv
// Bit-serial RX parity checker with registered done/error pulses.
// Optional saturating error counter enabled by macro UART_PAR_ERR_CNT_EN.
//
// state     | meaning
// ST_IDLE   | no frame armed; strobes ignored
// ST_DATA   | accumulating parity over data bits
// ST_PARITY | waiting for the received parity bit
module uart_rx_parity_chk
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 PAR_EN,
   input  logic [1:0]           PAR_TYP,
   input  logic                 frame_start,
   input  logic                 bit_valid,
   input  logic                 sampled_bit,
   output logic                 busy,
   output logic                 par_done,
   output logic                 par_err
`ifdef UART_PAR_ERR_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] par_err_cnt
`endif
);

   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   if (DATA_WIDTH < UART_MIN_DW || DATA_WIDTH > UART_MAX_DW) begin : g_bad_dw
      $error("uart_rx_parity_chk: DATA_WIDTH out of range");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cw
      $error("uart_rx_parity_chk: CNT_WIDTH must be positive");
   end

   par_state_e    state;
   logic          acc;
   logic [BW-1:0] bit_cnt;
   logic          cfg_par_en;
   logic [1:0]    cfg_par_typ;
   logic          exp_bit;

   uart_par_expected u_par_expected (
      .par_typ (cfg_par_typ),
      .acc     (acc),
      .exp_bit (exp_bit)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= ST_IDLE;
         acc         <= 1'b0;
         bit_cnt     <= '0;
         cfg_par_en  <= 1'b0;
         cfg_par_typ <= 2'b00;
         par_done    <= 1'b0;
         par_err     <= 1'b0;
`ifdef UART_PAR_ERR_CNT_EN
         par_err_cnt <= '0;
`endif
      end else begin
         par_done <= 1'b0;
         par_err  <= 1'b0;
         // frame_start has priority: it aborts any frame and drops a coincident strobe
         if (frame_start) begin
            cfg_par_en  <= PAR_EN;
            cfg_par_typ <= PAR_TYP;
            acc         <= 1'b0;
            bit_cnt     <= '0;
            state       <= ST_DATA;
         end else if (bit_valid) begin
            case (state)
               ST_DATA: begin
                  acc <= acc ^ sampled_bit;
                  if (bit_cnt == LAST_BIT) begin
                     if (cfg_par_en) begin
                        state <= ST_PARITY;
                     end else begin
                        par_done <= 1'b1;
                        state    <= ST_IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_PARITY: begin
                  par_done <= 1'b1;
                  par_err  <= (sampled_bit != exp_bit);
                  state    <= ST_IDLE;
`ifdef UART_PAR_ERR_CNT_EN
                  if ((sampled_bit != exp_bit) && (par_err_cnt != '1))
                     par_err_cnt <= par_err_cnt + 1'b1;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_parity_chk.sv
// Self-checking bench: DATA_WIDTH=8 and DATA_WIDTH=7 instances, directed plus random frames.
module tb_uart_rx_parity_chk;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       sel = 1'b0;
   logic       par_en = 1'b0;
   logic [1:0] par_typ = 2'b00;
   logic       fs = 1'b0;
   logic       bv = 1'b0;
   logic       sb = 1'b0;

   logic busy8, done8, err8, busy7, done7, err7;
   logic [1:0] cnt8, cnt7;

   int checks = 0;
   int errors = 0;
   int cnt_model [2];

   always #5 CLK = ~CLK;

   uart_rx_parity_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (
      .CLK(CLK), .RST(RST), .PAR_EN(par_en & ~sel), .PAR_TYP(par_typ & {2{~sel}}),
      .frame_start(fs & ~sel), .bit_valid(bv & ~sel), .sampled_bit(sb & ~sel),
      .busy(busy8), .par_done(done8), .par_err(err8)
`ifdef UART_PAR_ERR_CNT_EN
      , .par_err_cnt(cnt8)
`endif
   );

   uart_rx_parity_chk #(.DATA_WIDTH(7), .CNT_WIDTH(2)) dut7 (
      .CLK(CLK), .RST(RST), .PAR_EN(par_en & sel), .PAR_TYP(par_typ & {2{sel}}),
      .frame_start(fs & sel), .bit_valid(bv & sel), .sampled_bit(sb & sel),
      .busy(busy7), .par_done(done7), .par_err(err7)
`ifdef UART_PAR_ERR_CNT_EN
      , .par_err_cnt(cnt7)
`endif
   );

`ifndef UART_PAR_ERR_CNT_EN
   assign cnt8 = 2'b00;
   assign cnt7 = 2'b00;
`endif

   wire busy_o = sel ? busy7 : busy8;
   wire done_o = sel ? done7 : done8;
   wire err_o  = sel ? err7  : err8;
   wire [1:0] cnt_o = sel ? cnt7 : cnt8;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: expected parity bit from the population count of the data bits.
   function automatic logic ref_par(input logic [8:0] data, input int dw, input logic [1:0] typ);
      int ones = 0;
      for (int i = 0; i < dw; i++) ones += int'(data[i]);
      case (typ)
         2'd0:    return logic'(ones % 2);
         2'd1:    return logic'((ones + 1) % 2);
         2'd2:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the strobe was consumed.
   task automatic drive_bit(input logic b);
      bv = 1'b1; sb = b;
      @(negedge CLK);
      bv = 1'b0;
   endtask

   task automatic start(input logic pe, input logic [1:0] typ);
      fs = 1'b1; par_en = pe; par_typ = typ;
      @(negedge CLK);
      fs = 1'b0;
      par_en = ~pe; par_typ = ~typ;   // mid-frame changes must not matter
      chk("busy_after_start", busy_o, 1'b1);
   endtask

   task automatic run_frame(input string tag, input logic s, input logic [8:0] data,
                            input logic pe, input logic [1:0] typ, input logic pb);
      int dw;
      logic exp_err;
      sel = s;
      dw = s ? 7 : 8;
      start(pe, typ);
      for (int i = 0; i < dw; i++) begin
         drive_bit(data[i]);
         if (i < dw - 1 || pe) chk({tag, "_no_early_done"}, done_o, 1'b0);
      end
      if (pe) drive_bit(pb);
      exp_err = pe ? (pb != ref_par(data, dw, typ)) : 1'b0;
      if (exp_err) cnt_model[s] = (cnt_model[s] < 3) ? cnt_model[s] + 1 : 3;
      chk({tag, "_done"}, done_o, 1'b1);
      chk({tag, "_err"}, err_o, exp_err);
      chk({tag, "_busy_low"}, busy_o, 1'b0);
`ifdef UART_PAR_ERR_CNT_EN
      chk({tag, "_cnt"}, cnt_o, cnt_model[s]);
`endif
      @(negedge CLK);
      chk({tag, "_done_one_cycle"}, done_o, 1'b0);
      chk({tag, "_err_one_cycle"}, err_o, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      cnt_model[0] = 0;
      cnt_model[1] = 0;
   endtask

   initial begin
      logic [8:0] rd;
      cnt_model[0] = 0;
      cnt_model[1] = 0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_err", err8, 1'b0);
      chk("rst_cnt", cnt8, 2'd0);
      RST = 1'b1;
      @(negedge CLK);

      run_frame("a5_even", 1'b0, 9'h0A5, 1'b1, 2'd0, 1'b0);
      run_frame("a5_odd",  1'b0, 9'h0A5, 1'b1, 2'd1, 1'b0);
      run_frame("dw7_mark",  1'b1, 9'h000, 1'b1, 2'd2, 1'b0);
      run_frame("dw7_space", 1'b1, 9'h000, 1'b1, 2'd3, 1'b0);
      run_frame("nopar_ff", 1'b0, 9'h0FF, 1'b0, 2'd0, 1'b0);
      drive_bit(1'b1);
      chk("extra_strobe_busy", busy8, 1'b0);
      chk("extra_strobe_done", done8, 1'b0);

      // Abort after four data bits, then a full clean frame.
      sel = 1'b0;
      start(1'b1, 2'd1);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      chk("abort_no_done", done8, 1'b0);
      run_frame("after_abort", 1'b0, 9'h001, 1'b1, 2'd0, 1'b1);

      // frame_start coincident with a strobe: the strobe is discarded.
      sel = 1'b0;
      fs = 1'b1; bv = 1'b1; sb = 1'b1; par_en = 1'b0; par_typ = 2'd0;
      @(negedge CLK);
      fs = 1'b0; bv = 1'b0;
      for (int i = 0; i < 7; i++) drive_bit(1'b0);
      chk("fs_wins_not_done", done8, 1'b0);
      drive_bit(1'b0);
      chk("fs_wins_done", done8, 1'b1);
      @(negedge CLK);

      // Counter saturation: five bad frames.
      do_reset();
      for (int k = 0; k < 5; k++) run_frame("sat", 1'b0, 9'h0A5, 1'b1, 2'd0, 1'b1);

      for (int k = 0; k < 24; k++) begin
         rd = 9'($urandom);
         run_frame("rand", 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            drive_bit(1'($urandom));
            chk("idle_strobe_done", done_o, 1'b0);
         end
      end

      // Reset mid-frame drops the frame.
      sel = 1'b0;
      start(1'b1, 2'd0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      RST = 1'b0;
      @(negedge CLK);
      cnt_model[0] = 0;
      cnt_model[1] = 0;
      chk("midrst_busy", busy8, 1'b0);
      chk("midrst_done", done8, 1'b0);
      chk("midrst_err", err8, 1'b0);
      chk("midrst_cnt", cnt8, 2'd0);
      RST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_bit(1'b1);
         chk("post_rst_idle", done8, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
